// File: rtl/tap_mux_pkg.sv
// Shared types and constants for the sequenced tap multiplexer.
package tap_mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_SWEEP = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

endpackage

// File: rtl/mux_n_1.sv
// Purely combinational W-bit N:1 multiplexer; out is zero for any sel >= N.
module mux_n_1 #(
    parameter  int W    = 9,
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N*W-1:0]  in_bus,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    out
);

    always_comb begin
        out = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel == SELW'(i)) out = in_bus[i*W +: W];
        end
    end

endmodule

// File: rtl/tap_mux_seq.sv
// Sequenced N-input tap multiplexer: sweeps or presents one word per start
// pulse through a registered valid/ready output stage.
module tap_mux_seq
    import tap_mux_pkg::*;
#(
    parameter  int W    = 9,
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mode,
    input  logic [SELW-1:0] fixed_sel,
    input  logic [N*W-1:0]  in_bus,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    localparam logic [SELW-1:0] LAST_IDX = SELW'(N - 1);

    state_t          state;
    logic [SELW-1:0] next_sel;
    logic [W-1:0]    mux_word;

    // Index of the word loaded at the next load edge: first index when idle,
    // successor of the presented index while running.
    always_comb begin
        next_sel = out_sel + SELW'(1);
        if (state == IDLE) next_sel = (mode == MODE_FIXED) ? fixed_sel : '0;
    end

    mux_n_1 #(
        .W(W),
        .N(N)
    ) u_mux (
        .in_bus(in_bus),
        .sel   (next_sel),
        .out   (mux_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        out_valid <= 1'b1;
                        out_sel   <= next_sel;
                        out_data  <= mux_word;
                        out_last  <= (mode == MODE_FIXED) || (next_sel == LAST_IDX);
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    // out_last alone decides termination, so mode is never re-read here.
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_sel  <= next_sel;
                            out_data <= mux_word;
                            out_last <= (next_sel == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tap_mux_seq.sv
// Directed self-checking bench for tap_mux_seq (N=4 and N=3 instances).
module tb_tap_mux_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, mode, out_ready;
    logic [1:0]  fixed_sel;
    logic [35:0] in_bus;
    logic [8:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid, out_last, busy, done;

    logic        start3, mode3;
    logic [1:0]  fixed3;
    logic [26:0] in_bus3;
    logic [8:0]  d3_data;
    logic [1:0]  d3_sel;
    logic        d3_valid, d3_last, d3_busy, d3_done;

    int errors = 0;
    int checks = 0;

    // status vector: {valid, last, busy, done, sel[1:0], data[8:0]}
    logic [14:0] st, st3;
    assign st  = {out_valid, out_last, busy, done, out_sel, out_data};
    assign st3 = {d3_valid, d3_last, d3_busy, d3_done, d3_sel, d3_data};

    always #5 clk = ~clk;

    tap_mux_seq #(.W(9), .N(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .fixed_sel(fixed_sel),
        .in_bus(in_bus), .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
    );

    tap_mux_seq #(.W(9), .N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3), .fixed_sel(fixed3),
        .in_bus(in_bus3), .out_data(d3_data), .out_sel(d3_sel), .out_valid(d3_valid),
        .out_ready(1'b1), .out_last(d3_last), .busy(d3_busy), .done(d3_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; fixed_sel = 2'd0; out_ready = 1'b1;
        in_bus = {9'h1AA, 9'h100, 9'h0FF, 9'h001};
        start3 = 1'b0; mode3 = 1'b0; fixed3 = 2'd0;
        in_bus3 = {9'h033, 9'h022, 9'h011};
        #3;
        checks++;
        if (st !== 15'd0) begin
            errors++; $display("FAIL reset_n4 act=%h exp=%h", st, 15'd0);
        end
        checks++;
        if (st3 !== 15'd0) begin
            errors++; $display("FAIL reset_n3 act=%h exp=%h", st3, 15'd0);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sweep();
        logic [8:0]  words [4] = '{9'h001, 9'h0FF, 9'h100, 9'h1AA};
        logic [14:0] exp;
        mode = 1'b0; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, (i == 3), 1'b1, 1'b0, 2'(i), words[i]};
            checks++;
            if (st !== exp) begin
                errors++; $display("FAIL sweep_idx%0d act=%h exp=%h", i, st, exp);
            end
            tick();
        end
        checks++;
        if ({out_valid, out_last, busy, done} !== 4'b0001) begin
            errors++; $display("FAIL sweep_done act=%b exp=0001", {out_valid, out_last, busy, done});
        end
        tick();
        checks++;
        if ({out_valid, busy, done} !== 3'b000) begin
            errors++; $display("FAIL sweep_after act=%b exp=000", {out_valid, busy, done});
        end
    endtask

    task automatic test_backpressure();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        out_ready = 1'b0;
        in_bus[17:9] = 9'h055;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (st !== {4'b1010, 2'd1, 9'h0FF}) begin
                errors++; $display("FAIL stall_cyc%0d act=%h exp=%h", i, st, {4'b1010, 2'd1, 9'h0FF});
            end
            tick();
        end
        out_ready = 1'b1;
        checks++;
        if (st !== {4'b1010, 2'd1, 9'h0FF}) begin
            errors++; $display("FAIL stall_release act=%h exp=%h", st, {4'b1010, 2'd1, 9'h0FF});
        end
        tick();
        checks++;
        if (st !== {4'b1010, 2'd2, 9'h100}) begin
            errors++; $display("FAIL stall_resume act=%h exp=%h", st, {4'b1010, 2'd2, 9'h100});
        end
        tick();
        checks++;
        if (st !== {4'b1110, 2'd3, 9'h1AA}) begin
            errors++; $display("FAIL stall_last act=%h exp=%h", st, {4'b1110, 2'd3, 9'h1AA});
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL stall_done act=%b exp=1", done);
        end
        in_bus[17:9] = 9'h0FF;
        tick();
    endtask

    task automatic test_fixed();
        mode = 1'b1; fixed_sel = 2'd2; start = 1'b1;
        tick();
        start = 1'b0; mode = 1'b0; fixed_sel = 2'd0;
        checks++;
        if (st !== {4'b1110, 2'd2, 9'h100}) begin
            errors++; $display("FAIL fixed_word act=%h exp=%h", st, {4'b1110, 2'd2, 9'h100});
        end
        tick();
        checks++;
        if ({out_valid, out_last, busy, done} !== 4'b0001) begin
            errors++; $display("FAIL fixed_done act=%b exp=0001", {out_valid, out_last, busy, done});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        checks++;
        if (out_sel !== 2'd2) begin
            errors++; $display("FAIL midrst_pre act=%0d exp=2", out_sel);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (st !== 15'd0) begin
            errors++; $display("FAIL midrst_async act=%h exp=%h", st, 15'd0);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL midrst_nodone act=%b exp=0", done);
        end
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (st !== {4'b1010, 2'd0, 9'h001}) begin
            errors++; $display("FAIL midrst_restart act=%h exp=%h", st, {4'b1010, 2'd0, 9'h001});
        end
        tick(); tick(); tick(); tick(); tick();
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        tick();
        tick();
        checks++;
        if (st !== {4'b1010, 2'd1, 9'h0FF}) begin
            errors++; $display("FAIL b2b_ignored act=%h exp=%h", st, {4'b1010, 2'd1, 9'h0FF});
        end
        tick(); tick();
        checks++;
        if (st !== {4'b1110, 2'd3, 9'h1AA}) begin
            errors++; $display("FAIL b2b_last act=%h exp=%h", st, {4'b1110, 2'd3, 9'h1AA});
        end
        tick();
        checks++;
        if ({out_valid, busy, done} !== 3'b001) begin
            errors++; $display("FAIL b2b_done act=%b exp=001", {out_valid, busy, done});
        end
        tick();
        start = 1'b0;
        checks++;
        if (st !== {4'b1010, 2'd0, 9'h001}) begin
            errors++; $display("FAIL b2b_second act=%h exp=%h", st, {4'b1010, 2'd0, 9'h001});
        end
        tick(); tick(); tick(); tick();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL b2b_second_done act=%b exp=1", done);
        end
        tick();
    endtask

    task automatic test_n3();
        mode3 = 1'b1; fixed3 = 2'd3; start3 = 1'b1;
        tick();
        start3 = 1'b0; mode3 = 1'b0;
        checks++;
        if (st3 !== {4'b1110, 2'd3, 9'h000}) begin
            errors++; $display("FAIL n3_oob act=%h exp=%h", st3, {4'b1110, 2'd3, 9'h000});
        end
        tick();
        checks++;
        if ({d3_valid, d3_busy, d3_done} !== 3'b001) begin
            errors++; $display("FAIL n3_oob_done act=%b exp=001", {d3_valid, d3_busy, d3_done});
        end
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        tick(); tick();
        checks++;
        if (st3 !== {4'b1110, 2'd2, 9'h033}) begin
            errors++; $display("FAIL n3_sweep_last act=%h exp=%h", st3, {4'b1110, 2'd2, 9'h033});
        end
        tick();
        checks++;
        if (d3_done !== 1'b1) begin
            errors++; $display("FAIL n3_sweep_done act=%b exp=1", d3_done);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_backpressure();
        test_fixed();
        test_reset_mid();
        test_back_to_back();
        test_n3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
